// File: rtl/fpu_reg_pkg.sv
// fpu_reg_pkg: register offsets, issue-FSM states and STATUS bit
// positions shared by the queued FPU register bank.
package fpu_reg_pkg;

    localparam logic [31:0] OFF_OPA       = 32'h00;
    localparam logic [31:0] OFF_OPB       = 32'h04;
    localparam logic [31:0] OFF_OPC       = 32'h08;
    localparam logic [31:0] OFF_RESULT    = 32'h0C;
    localparam logic [31:0] OFF_RES_OP    = 32'h10;
    localparam logic [31:0] OFF_STATUS    = 32'h14;
    localparam logic [31:0] OFF_CTRL      = 32'h18;
    localparam logic [31:0] OFF_OPERATION = 32'h1C;
    localparam logic [31:0] OFF_FFLAGS    = 32'h20;
    localparam logic [31:0] OFF_FRM       = 32'h24;
    localparam logic [31:0] OFF_FCSR      = 32'h28;

    localparam int ST_BUSY      = 8;
    localparam int ST_CMD_OVF   = 9;
    localparam int ST_BAD_OP    = 10;
    localparam int ST_UNDERFLOW = 11;
    localparam int ST_SPURIOUS  = 12;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: synchronous FIFO with zero-latency head, flush and
// occupancy count; a pop on a full FIFO frees room for a same-cycle push.
module fpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_reg_bank_q.sv
// fpu_reg_bank_q: memory-mapped FPU register bank with queued command
// snapshots, a one-at-a-time issue FSM and a buffered result queue.
module fpu_reg_bank_q
    import fpu_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_OPS   = 13,
    parameter int          QDEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic               wren,
    input  logic               rden,
    input  logic [31:0]        wrdata,
    output logic [31:0]        rddata,
    output logic               ack,
    output logic [NUM_OPS-1:0] op_valids,
    output logic [31:0]        opA,
    output logic [31:0]        opB,
    output logic [31:0]        opC,
    output logic [2:0]         frm,
    input  logic [31:0]        fpu_result,
    input  logic [NUM_OPS-1:0] fpu_valids,
    input  logic [4:0]         exceptions,
    output logic               irq
);

    localparam int CW = NUM_OPS + 99;
    localparam int RW = NUM_OPS + 32;
    localparam int QW = $clog2(QDEPTH) + 1;

    state_t             state;
    logic [31:0]        off;
    logic [31:0]        rd_val;
    logic [31:0]        status;
    logic               mapped;
    logic [31:0]        stage_a, stage_b, stage_c;
    logic [2:0]         frm_reg;
    logic [4:0]         fflags;
    logic               irq_en;
    logic               cmd_ovf, bad_op, underflow, spurious;

    logic [CW-1:0]      cmd_head;
    logic [QW-1:0]      cmd_count;
    logic               cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [RW-1:0]      res_head;
    logic [QW-1:0]      res_count;
    logic               res_full, res_empty, res_pop;

    logic               op_wr, op_hot, flush;
    logic               res_valid, busy, capture, go;

    assign off       = addr - BASE_ADDR;
    assign op_wr     = wren & (off == OFF_OPERATION);
    assign op_hot    = $onehot(wrdata[NUM_OPS-1:0]);
    assign flush     = wren & (off == OFF_CTRL) & wrdata[CTRL_FLUSH];
    assign cmd_push  = op_wr & op_hot & ~cmd_full;
    assign cmd_pop   = (state == ISSUE);
    assign res_pop   = rden & (off == OFF_RESULT);
    assign res_valid = |fpu_valids;
    assign busy      = (state != IDLE);
    assign capture   = res_valid & busy;
    assign go        = (state == IDLE) & ~cmd_empty & ~res_full;
    assign irq       = irq_en & ~res_empty;

    fpu_sync_fifo #(.WIDTH(CW), .DEPTH(QDEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .flush (flush),
        .din   ({wrdata[NUM_OPS-1:0], stage_a, stage_b, stage_c, frm_reg}),
        .dout  (cmd_head),
        .count (cmd_count),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    fpu_sync_fifo #(.WIDTH(RW), .DEPTH(QDEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (res_pop),
        .flush (flush),
        .din   ({fpu_result, fpu_valids}),
        .dout  (res_head),
        .count (res_count),
        .full  (res_full),
        .empty (res_empty)
    );

    always_comb begin
        status                = '0;
        status[3:0]           = 4'(cmd_count);
        status[7:4]           = 4'(res_count);
        status[ST_BUSY]       = busy;
        status[ST_CMD_OVF]    = cmd_ovf;
        status[ST_BAD_OP]     = bad_op;
        status[ST_UNDERFLOW]  = underflow;
        status[ST_SPURIOUS]   = spurious;
    end

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (off)
            OFF_OPA:       rd_val = stage_a;
            OFF_OPB:       rd_val = stage_b;
            OFF_OPC:       rd_val = stage_c;
            OFF_RESULT:    rd_val = res_empty ? '0 : res_head[RW-1 -: 32];
            OFF_RES_OP:    rd_val = res_empty ? '0 : 32'(res_head[NUM_OPS-1:0]);
            OFF_STATUS:    rd_val = status;
            OFF_CTRL:      rd_val = {31'b0, irq_en};
            OFF_OPERATION: rd_val = '0;
            OFF_FFLAGS:    rd_val = {27'b0, fflags};
            OFF_FRM:       rd_val = {29'b0, frm_reg};
            OFF_FCSR:      rd_val = {24'b0, frm_reg, fflags};
            default:       mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            rddata    <= '0;
            stage_a   <= '0;
            stage_b   <= '0;
            stage_c   <= '0;
            frm_reg   <= '0;
            fflags    <= '0;
            irq_en    <= 1'b0;
            cmd_ovf   <= 1'b0;
            bad_op    <= 1'b0;
            underflow <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            ack    <= (wren | rden) & mapped;
            rddata <= (rden & mapped) ? rd_val : '0;
            if (wren && off == OFF_OPA)  stage_a <= wrdata;
            if (wren && off == OFF_OPB)  stage_b <= wrdata;
            if (wren && off == OFF_OPC)  stage_c <= wrdata;
            if (wren && off == OFF_CTRL) irq_en  <= wrdata[CTRL_IRQ_EN];
            if (wren && off == OFF_FRM)  frm_reg <= wrdata[2:0];
            if (wren && off == OFF_FCSR) frm_reg <= wrdata[7:5];
            // a CSR write racing a capture must not lose the new flags
            if (wren && (off == OFF_FFLAGS || off == OFF_FCSR))
                fflags <= wrdata[4:0] | (capture ? exceptions : 5'b0);
            else if (capture)
                fflags <= fflags | exceptions;
            if (flush) begin
                cmd_ovf   <= 1'b0;
                bad_op    <= 1'b0;
                underflow <= 1'b0;
                spurious  <= 1'b0;
            end else begin
                if (op_wr && !op_hot)             bad_op    <= 1'b1;
                if (op_wr && op_hot && cmd_full)  cmd_ovf   <= 1'b1;
                if (res_pop && res_empty)         underflow <= 1'b1;
                if (res_valid && !busy)           spurious  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_valids <= '0;
            opA       <= '0;
            opB       <= '0;
            opC       <= '0;
            frm       <= '0;
        end else begin
            op_valids <= '0;
            if (flush) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: if (go) begin
                        state     <= ISSUE;
                        op_valids <= cmd_head[CW-1 -: NUM_OPS];
                        opA       <= cmd_head[98:67];
                        opB       <= cmd_head[66:35];
                        opC       <= cmd_head[34:3];
                        frm       <= cmd_head[2:0];
                    end
                    ISSUE:   state <= res_valid ? IDLE : WAIT;
                    WAIT:    if (res_valid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
